// File: rtl/cam_window_capture.sv
`default_nettype none
// ============================================================================
// cam_window_capture: OV7670-style RGB565 capture into a cropped frame RAM
// Revision: 1.0
// ============================================================================
module cam_window_capture #(
   parameter int PIX_W   = 16,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int CROP_X0 = 0,
   parameter int CROP_Y0 = 0,
   parameter int CROP_W  = 80,
   parameter int CROP_H  = 60,
   parameter int ADDR_W  = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmos_pclk,
   input  logic              cmos_href,
   input  logic              cmos_vsync,
   input  logic [7:0]        cmos_db,
   input  logic              cfg_done,
   input  logic              mode,
   input  logic              snap_req,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              frame_valid,
   output logic              frame_done,
   output logic              short_frame
);
   localparam int c_depth = CROP_W * CROP_H;
   localparam int c_xw    = $clog2(IMG_W + 1);
   localparam int c_yw    = $clog2(IMG_H + 1);
   localparam int c_pw    = ADDR_W + 1;
   localparam int c_mw    = (c_depth > 1) ? $clog2(c_depth) : 1;

   localparam logic [c_xw-1:0] c_x0   = c_xw'(CROP_X0);
   localparam logic [c_xw-1:0] c_cw   = c_xw'(CROP_W);
   localparam logic [c_xw-1:0] c_xmax = c_xw'(IMG_W);
   localparam logic [c_yw-1:0] c_y0   = c_yw'(CROP_Y0);
   localparam logic [c_yw-1:0] c_ch   = c_yw'(CROP_H);
   localparam logic [c_yw-1:0] c_ymax = c_yw'(IMG_H);
   localparam logic [c_pw-1:0] c_dep  = c_pw'(c_depth);

   if (c_depth > 2**ADDR_W) begin : g_depth_check
      $error("cam_window_capture: CROP_W*CROP_H exceeds 2**ADDR_W");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VS = 2'd1,
      S_CAPT    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        pclk_q, pclk_d;
   logic [2:0]        href_q, href_d, vsync_q, vsync_d;
   logic [1:0][7:0]   db_q, db_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic [c_xw-1:0]   x_q, x_d;
   logic [c_yw-1:0]   y_q, y_d;
   logic [c_pw-1:0]   wr_ptr_q, wr_ptr_d;
   logic              wr_req_q, wr_req_d;
   logic [PIX_W-1:0]  wr_data_q, wr_data_d;
   logic              frame_valid_q, frame_valid_d;
   logic              short_frame_q, short_frame_d;
   logic [PIX_W-1:0]  rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic              pclk_rise, href_rise, href_fall, vsync_rise, vsync_fall;
   logic              pix_stb, in_win, wr_en;
   logic [PIX_W-1:0]  pix_word;
   logic [PIX_W-1:0]  mem [c_depth];

   if (PIX_W == 16) begin : g_pix16
      assign pix_word = {hi_q, db_q[1]};
   end else begin : g_pix8
      assign pix_word = hi_q;
   end

   assign pclk_rise  = pclk_q[0] & ~pclk_q[1];
   assign href_rise  = href_q[1] & ~href_q[2];
   assign href_fall  = ~href_q[1] & href_q[2];
   assign vsync_rise = vsync_q[1] & ~vsync_q[2];
   assign vsync_fall = ~vsync_q[1] & vsync_q[2];
   // Subtraction wraps negative offsets far above the crop size.
   assign in_win     = ((x_q - c_x0) < c_cw) && ((y_q - c_y0) < c_ch);
   assign wr_en      = wr_req_q && (wr_ptr_q != c_dep);

   always_comb begin
      pclk_d        = {pclk_q[0], cmos_pclk};
      href_d        = {href_q[1:0], cmos_href};
      vsync_d       = {vsync_q[1:0], cmos_vsync};
      db_d          = {db_q[0], cmos_db};
      phase_d       = phase_q;
      hi_d          = hi_q;
      pix_stb       = 1'b0;
      x_d           = x_q;
      y_d           = y_q;
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      frame_valid_d = frame_valid_q;
      short_frame_d = short_frame_q;
      rd_valid_d    = rd_en;
      rd_data_d     = rd_data_q;

      if (href_rise) phase_d = 1'b0;
      if (pclk_rise && href_q[1]) begin
         if (href_rise || !phase_q) begin
            hi_d    = db_q[1];
            phase_d = 1'b1;
         end else begin
            pix_stb = 1'b1;
            phase_d = 1'b0;
         end
      end

      if (pix_stb && x_q != c_xmax) x_d = x_q + c_xw'(1);
      if (href_fall) begin
         x_d = '0;
         if (y_q != c_ymax) y_d = y_q + c_yw'(1);
      end
      if (vsync_fall) begin
         x_d = '0;
         y_d = '0;
      end

      // Qualified at strobe time so a pixel coinciding with vsync rise still lands.
      wr_req_d  = pix_stb && in_win && (state_q == S_CAPT);
      wr_data_d = pix_stb ? pix_word : wr_data_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + c_pw'(1);

      case (state_q)
         S_IDLE: begin
            if (cfg_done && (mode || snap_req)) begin
               state_d = S_WAIT_VS;
               if (!mode) frame_valid_d = 1'b0;
            end
         end
         S_WAIT_VS: begin
            if (vsync_fall) begin
               state_d  = S_CAPT;
               wr_ptr_d = '0;
            end
         end
         S_CAPT: begin
            if (vsync_rise) state_d = S_DONE;
         end
         S_DONE: begin
            if (wr_ptr_d == c_dep) frame_valid_d = 1'b1;
            else                   short_frame_d = 1'b1;
            state_d = (mode && cfg_done) ? S_WAIT_VS : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (!cfg_done) state_d = S_IDLE;

      if (rd_en) rd_data_d = ({1'b0, rd_addr} < c_dep) ? mem[rd_addr[c_mw-1:0]] : '0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[c_mw-1:0]] <= wr_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pclk_q        <= '0;
         href_q        <= '0;
         vsync_q       <= '0;
         db_q          <= '0;
         phase_q       <= 1'b0;
         hi_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         wr_ptr_q      <= '0;
         wr_req_q      <= 1'b0;
         wr_data_q     <= '0;
         frame_valid_q <= 1'b0;
         short_frame_q <= 1'b0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pclk_q        <= pclk_d;
         href_q        <= href_d;
         vsync_q       <= vsync_d;
         db_q          <= db_d;
         phase_q       <= phase_d;
         hi_q          <= hi_d;
         x_q           <= x_d;
         y_q           <= y_d;
         wr_ptr_q      <= wr_ptr_d;
         wr_req_q      <= wr_req_d;
         wr_data_q     <= wr_data_d;
         frame_valid_q <= frame_valid_d;
         short_frame_q <= short_frame_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_valid = frame_valid_q;
   assign frame_done  = (state_q == S_DONE);
   assign short_frame = short_frame_q;
endmodule
`default_nettype wire

// File: tb/tb_cam_window_capture.sv
`default_nettype none
// ============================================================================
// tb_cam_window_capture: directed/random capture scenarios against a window model
// Revision: 1.0
// ============================================================================
module tb_cam_window_capture;
   localparam int IMG_W = 8, IMG_H = 6, X0 = 2, Y0 = 1, CW = 4, CH = 3, AW = 4;
   localparam int DEPTH = CW * CH;

   logic clk = 1'b0;
   logic rst, pclk, href, vsync, cfg_done, mode, snap_req, rd_en;
   logic [7:0] db;
   logic [AW-1:0] rd_addr;
   logic [15:0] rd_data;
   logic [7:0]  rd_data8;
   logic rd_valid, busy, frame_valid, frame_done, short_frame;
   logic rd_valid8, busy8, frame_valid8, frame_done8, short_frame8;

   cam_window_capture #(.PIX_W(16), .IMG_W(IMG_W), .IMG_H(IMG_H), .CROP_X0(X0), .CROP_Y0(Y0),
                        .CROP_W(CW), .CROP_H(CH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .cmos_pclk(pclk), .cmos_href(href), .cmos_vsync(vsync), .cmos_db(db),
      .cfg_done(cfg_done), .mode(mode), .snap_req(snap_req), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .frame_valid(frame_valid),
      .frame_done(frame_done), .short_frame(short_frame));

   cam_window_capture #(.PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .CROP_X0(X0), .CROP_Y0(Y0),
                        .CROP_W(CW), .CROP_H(CH), .ADDR_W(AW)) dut8 (
      .clk(clk), .rst(rst), .cmos_pclk(pclk), .cmos_href(href), .cmos_vsync(vsync), .cmos_db(db),
      .cfg_done(cfg_done), .mode(mode), .snap_req(snap_req), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data8), .rd_valid(rd_valid8), .busy(busy8), .frame_valid(frame_valid8),
      .frame_done(frame_done8), .short_frame(short_frame8));

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;
   int fd_cnt = 0, fd_base;
   logic mon_busy = 1'b0, busy_drop = 1'b0;
   logic [15:0] pix [IMG_H][IMG_W];
   logic [15:0] exp_mem [DEPTH];
   int exp_cnt;
   logic exp_fv, exp_sf;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (mon_busy && !busy) busy_drop = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_frame(input bit pattern);
      for (int y = 0; y < IMG_H; y++)
         for (int x = 0; x < IMG_W; x++)
            pix[y][x] = pattern ? {8'(y), 8'(x)} : 16'($urandom);
   endtask

   // Row-major window contents after a frame of nlines lines; unwritten words keep old data.
   task automatic model_frame(input int nlines);
      int idx = 0;
      for (int y = 0; y < nlines; y++)
         for (int x = 0; x < IMG_W; x++)
            if (x >= X0 && x < X0 + CW && y >= Y0 && y < Y0 + CH && idx < DEPTH) begin
               exp_mem[idx] = pix[y][x];
               idx++;
            end
      exp_cnt = idx;
   endtask

   task automatic model_done();
      if (exp_cnt == DEPTH) exp_fv = 1'b1;
      else                  exp_sf = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      db = b; pclk = 1'b0; tick(4);
      pclk = 1'b1; tick(4);
   endtask

   task automatic send_line(input int y);
      href = 1'b1;
      for (int x = 0; x < IMG_W; x++) begin
         send_byte(pix[y][x][15:8]);
         send_byte(pix[y][x][7:0]);
      end
      pclk = 1'b0; href = 1'b0; tick(8);
   endtask

   task automatic start_frame();
      vsync = 1'b1; tick(6);
      vsync = 1'b0; tick(8);
   endtask

   task automatic end_frame();
      vsync = 1'b1; tick(12);
   endtask

   task automatic send_frame(input int nlines);
      start_frame();
      for (int y = 0; y < nlines; y++) send_line(y);
      end_frame();
   endtask

   task automatic snap_pulse();
      snap_req = 1'b1; tick(1);
      snap_req = 1'b0;
   endtask

   task automatic rd_chk(input int a);
      logic [15:0] e;
      e = 16'h0;
      if (a < DEPTH) e = exp_mem[a];
      rd_en = 1'b1; rd_addr = AW'(a);
      tick(1);
      chk($sformatf("rd_valid[%0d]", a), rd_valid, 1);
      chk($sformatf("rd_data[%0d]", a), rd_data, e);
      chk($sformatf("rd_data8[%0d]", a), rd_data8, e[15:8]);
      rd_en = 1'b0;
   endtask

   task automatic rd_all();
      for (int a = 0; a < DEPTH; a++) rd_chk(a);
      tick(1);
      chk("rd_valid_idle", rd_valid, 0);
   endtask

   task automatic frame_status(input string tag);
      chk({tag, "_frame_done"}, fd_cnt, fd_base + ((exp_cnt >= 0) ? 1 : 0));
      chk({tag, "_frame_valid"}, frame_valid, exp_fv);
      chk({tag, "_short"}, short_frame, exp_sf);
      chk({tag, "_frame_valid8"}, frame_valid8, exp_fv);
   endtask

   initial begin
      rst = 1'b1; pclk = 1'b0; href = 1'b0; vsync = 1'b1; db = 8'h00;
      cfg_done = 1'b0; mode = 1'b0; snap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
      exp_fv = 1'b0; exp_sf = 1'b0; exp_cnt = 0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'h0;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_short", short_frame, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);

      // Snapshot of the {y,x} pattern frame, full-width and high-byte builds together.
      cfg_done = 1'b1; mode = 1'b0;
      snap_pulse();
      exp_fv = 1'b0;
      chk("snap_busy", busy, 1);
      fill_frame(1'b1); model_frame(IMG_H); fd_base = fd_cnt;
      send_frame(IMG_H); model_done();
      frame_status("snap");
      chk("snap_idle", busy, 0);
      chk("snap_fd8_idle", busy8, 0);
      rd_all();
      rd_chk(12);
      rd_chk(15);

      // Frame ends before the last window row is reached.
      snap_pulse(); exp_fv = 1'b0;
      fill_frame(1'b0); model_frame(3); fd_base = fd_cnt;
      send_frame(3); model_done();
      frame_status("short");
      chk("short_idle", busy, 0);
      rd_all();

      // Continuous mode, three random frames without leaving busy.
      mode = 1'b1; tick(2);
      mon_busy = 1'b1;
      for (int f = 0; f < 3; f++) begin
         fill_frame(1'b0); model_frame(IMG_H); fd_base = fd_cnt;
         send_frame(IMG_H); model_done();
         frame_status($sformatf("cont%0d", f));
      end
      mon_busy = 1'b0;
      chk("cont_busy_held", busy_drop, 0);
      chk("cont_busy", busy, 1);
      rd_all();

      mode = 1'b0; cfg_done = 1'b0;
      tick(1);
      chk("cfg_drop_idle", busy, 0);
      cfg_done = 1'b1; tick(2);

      // snap_req during capture must not queue a second frame.
      snap_pulse(); exp_fv = 1'b0;
      fill_frame(1'b0); model_frame(IMG_H); fd_base = fd_cnt;
      start_frame();
      send_line(0);
      snap_pulse();
      for (int y = 1; y < IMG_H; y++) send_line(y);
      end_frame(); model_done();
      frame_status("snapreq");
      chk("snapreq_idle", busy, 0);

      // cfg_done lost mid-frame: no completion, partial data stays in RAM.
      snap_pulse(); exp_fv = 1'b0;
      fill_frame(1'b0); model_frame(2); fd_base = fd_cnt;
      start_frame();
      send_line(0); send_line(1);
      cfg_done = 1'b0;
      tick(1);
      chk("cfgdrop_busy", busy, 0);
      for (int y = 2; y < IMG_H; y++) send_line(y);
      end_frame();
      chk("cfgdrop_no_done", fd_cnt, fd_base);
      chk("cfgdrop_frame_valid", frame_valid, 0);
      rd_all();
      cfg_done = 1'b1;

      // Reset in the middle of a line, then a clean snapshot.
      snap_pulse(); exp_fv = 1'b0;
      fill_frame(1'b0);
      start_frame();
      href = 1'b1;
      for (int x = 0; x < 3; x++) begin
         send_byte(pix[0][x][15:8]);
         send_byte(pix[0][x][7:0]);
      end
      rd_en = 1'b1; rd_addr = '0; rst = 1'b1;
      tick(1);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_valid", frame_valid, 0);
      chk("midrst_frame_done", frame_done, 0);
      chk("midrst_short", short_frame, 0);
      chk("midrst_rd_valid", rd_valid, 0);
      chk("midrst_rd_data", rd_data, 0);
      chk("midrst_rd_data8", rd_data8, 0);
      rst = 1'b0; rd_en = 1'b0; pclk = 1'b0; href = 1'b0;
      exp_fv = 1'b0; exp_sf = 1'b0;
      tick(8);
      snap_pulse();
      fill_frame(1'b0); model_frame(IMG_H); fd_base = fd_cnt;
      send_frame(IMG_H); model_done();
      frame_status("postrst");
      rd_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
